// File: rtl/backlight_pkg.sv
// backlight_pkg
//   Definitions shared by the backlight control stage and the backlight PWM
//   generator: default channel count and duty width, plus the per-period duty
//   slew rule.
package backlight_pkg;

    localparam int unsigned PWM_WIDTH_DEFAULT    = 12;
    localparam int unsigned PWM_CHANNELS_DEFAULT = 3;

    // Moves applied duty one slew step toward target. It never passes the
    // target. A step of 0 jumps straight to the target. Callers zero-extend
    // duties narrower than 32 bits, so the differences below cannot wrap.
    function automatic logic [31:0] slew_step(
        input logic [31:0] applied,
        input logic [31:0] target,
        input logic [31:0] step
    );
        logic [31:0] diff;
        if (step == '0) begin
            return target;
        end
        if (target > applied) begin
            diff = target - applied;
            return (diff > step) ? applied + step : target;
        end
        diff = applied - target;
        return (diff > step) ? applied - step : target;
    endfunction

endpackage

// File: rtl/backlight_pwm_channel.sv
// backlight_pwm_channel
//   One PWM channel. It holds the captured target and the applied duty, and it
//   drives the registered compare output.
//   Ports:
//     clock, reset_n : system clock and asynchronous active-low reset
//     enable         : global output enable; while low, applied duty is held at 0
//     wrap           : period wrap strobe from the shared period counter
//     count          : shared period counter value
//     load, value    : target capture strobe and target duty
//     pwm_out        : registered PWM output
//     ramping        : high while applied duty differs from target
module backlight_pwm_channel
    import backlight_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = PWM_WIDTH_DEFAULT,
    parameter int unsigned SLEW_STEP = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 wrap,
    input  logic [PWM_WIDTH-1:0] count,
    input  logic                 load,
    input  logic [PWM_WIDTH-1:0] value,
    output logic                 pwm_out,
    output logic                 ramping
);

    logic [PWM_WIDTH-1:0] target_q, target_d;
    logic [PWM_WIDTH-1:0] applied_q, applied_d;
    logic                 pwm_out_q, pwm_out_d;

    always_comb begin
        target_d  = target_q;
        applied_d = applied_q;
        pwm_out_d = 1'b0;

        if (load) begin
            target_d = value;
        end

        // Slew reads target_q. A load in the wrap cycle therefore first takes
        // effect at the following wrap.
        if (!enable) begin
            applied_d = '0;
        end else if (wrap) begin
            applied_d = PWM_WIDTH'(slew_step(32'(applied_q), 32'(target_q), SLEW_STEP));
        end

        pwm_out_d = enable && (count < applied_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            target_q  <= '0;
            applied_q <= '0;
            pwm_out_q <= 1'b0;
        end else begin
            target_q  <= target_d;
            applied_q <= applied_d;
            pwm_out_q <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;
    assign ramping = (applied_q != target_q);

endmodule

// File: rtl/backlight_pwm.sv
// backlight_pwm
//   Multi-channel backlight PWM generator. A shared prescaler and period counter
//   keep every channel phase-aligned. Each channel slews its applied duty toward
//   a captured target at period boundaries.
//   Ports:
//     clock, reset_n : system clock and asynchronous active-low reset
//     enable         : global output enable; while low, counters and duty are held at 0
//     pwm_load       : per-channel target capture strobes
//     pwm_value      : per-channel targets; channel k at [k*PWM_WIDTH +: PWM_WIDTH]
//     pwm_out        : registered PWM outputs
//     period_start   : one-cycle pulse in the cycle after each period wrap
//     ramping        : per-channel flag, high while applied duty differs from target
module backlight_pwm
    import backlight_pkg::*;
#(
    parameter int unsigned PWM_CHANNELS = PWM_CHANNELS_DEFAULT,
    parameter int unsigned PWM_WIDTH    = PWM_WIDTH_DEFAULT,
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned SLEW_STEP    = 16
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [PWM_CHANNELS-1:0]           pwm_load,
    input  logic [PWM_CHANNELS*PWM_WIDTH-1:0] pwm_value,
    output logic [PWM_CHANNELS-1:0]           pwm_out,
    output logic                              period_start,
    output logic [PWM_CHANNELS-1:0]           ramping
);

    localparam int unsigned MAX_COUNT = (2 ** PWM_WIDTH) - 1;
    localparam int unsigned PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PS_W-1:0]      PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] CNT_LAST = PWM_WIDTH'(MAX_COUNT - 1);

    logic [PS_W-1:0]      presc_q, presc_d;
    logic [PWM_WIDTH-1:0] count_q, count_d;
    logic                 period_start_q, period_start_d;
    logic                 tick;
    logic                 wrap;

    always_comb begin
        presc_d        = presc_q;
        count_d        = count_q;
        period_start_d = 1'b0;

        tick = (presc_q == PS_LAST);
        wrap = enable && tick && (count_q == CNT_LAST);

        // Holding both counters at 0 while disabled makes the first wrap after
        // enable rises land exactly one full period later.
        if (!enable) begin
            presc_d = '0;
            count_d = '0;
        end else if (tick) begin
            presc_d = '0;
            count_d = wrap ? '0 : count_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        period_start_d = wrap;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q        <= '0;
            count_q        <= '0;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            count_q        <= count_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    for (genvar k = 0; k < PWM_CHANNELS; k++) begin : g_channel
        backlight_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH),
            .SLEW_STEP (SLEW_STEP)
        ) u_channel (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (enable),
            .wrap    (wrap),
            .count   (count_q),
            .load    (pwm_load[k]),
            .value   (pwm_value[k*PWM_WIDTH +: PWM_WIDTH]),
            .pwm_out (pwm_out[k]),
            .ramping (ramping[k])
        );
    end

endmodule
